serial_add_unit: RTL

- Bit-serial add/subtract engine; the stage directly downstream of the parallel-to-serial operand shifters in the serial-adder CPU datapath.
- Latches two parallel operands on start and shifts both LSB-first through a one-bit full adder with a registered carry.
- Reassembles the sum into a parallel result register and raises a one-cycle done pulse with carry and overflow flags.
- Also exposes the sum bit stream, with a valid strobe, for serial consumers.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_full_adder_bit.sv | 52 +++++
 rtl/serial_add_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the bit-serial add/subtract unit.
//   sa_state_t   : controller states (IDLE -> SHIFT -> DONE -> IDLE)
//   P_WIDTH_DEF  : default operand width
//   cnt_width()  : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int P_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  // Counter only has to reach width-1, so $clog2(width) bits suffice.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_full_adder_bit.sv
// -----------------------------------------------------------------------------
// serial_full_adder_bit
// One-bit full adder with a registered carry, for LSB-first serial arithmetic.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (carry -> 0)
//   a_i, b_i       : current operand bits
//   load_i         : load the carry flop with cin_init_i (start of operation)
//   cin_init_i     : initial carry (1 for subtraction: A + ~B + 1)
//   en_i           : advance the carry by one bit position
//   sum_o          : a ^ b ^ carry (combinational)
//   carry_o        : carry flop value, i.e. carry into the current bit
//   carry_next_o   : carry out of the current bit
// load_i has priority over en_i.
// -----------------------------------------------------------------------------
module serial_full_adder_bit (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  input  logic load_i,
  input  logic cin_init_i,
  input  logic en_i,
  output logic sum_o,
  output logic carry_o,
  output logic carry_next_o
);

  logic carry_q;
  logic carry_d;

  assign sum_o        = a_i ^ b_i ^ carry_q;
  assign carry_next_o = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);
  assign carry_o      = carry_q;

  always_comb begin
    carry_d = carry_q;
    if (load_i) begin
      carry_d = cin_init_i;
    end else if (en_i) begin
      carry_d = carry_next_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/serial_add_unit.sv
// -----------------------------------------------------------------------------
// serial_add_unit
// Bit-serial add/subtract engine. Latches two parallel operands on start,
// shifts them LSB-first through a one-bit full adder and reassembles the sum.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request an operation (sampled in IDLE only)
//   sub          : 0 = A+B, 1 = A-B (sampled with start)
//   a_in, b_in   : operands (sampled with start)
//   busy         : high during the P_WIDTH SHIFT cycles
//   done         : one-cycle pulse, result/flags valid
//   sum_out      : parallel result, held until the next completion
//   carry_out    : final carry (subtract: 1 = no borrow, A >= B unsigned)
//   overflow     : signed overflow of the last operation
//   s_bit        : serial sum bit, LSB first (0 when s_valid is low)
//   s_valid      : s_bit is meaningful this cycle
//   state_dbg    : current controller state, for observation only
//
// Handshake: start is accepted on any rising edge where the unit is in IDLE;
// there is no back-pressure. Exactly P_WIDTH cycles later done pulses for one
// cycle, then the unit spends one cycle in IDLE before accepting start again.
// -----------------------------------------------------------------------------
module serial_add_unit
  import serial_adder_pkg::*;
#(
  parameter int P_WIDTH = P_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [P_WIDTH-1:0] a_in,
  input  logic [P_WIDTH-1:0] b_in,
  output logic               busy,
  output logic               done,
  output logic [P_WIDTH-1:0] sum_out,
  output logic               carry_out,
  output logic               overflow,
  output logic               s_bit,
  output logic               s_valid,
  output sa_state_t          state_dbg
);

  localparam int             CW   = cnt_width(P_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(P_WIDTH - 1);

  sa_state_t          state_q, state_d;
  logic [P_WIDTH-1:0] a_q, a_d;
  logic [P_WIDTH-1:0] b_q, b_d;
  logic [P_WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [P_WIDTH-1:0] sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic fa_load;
  logic fa_en;
  logic fa_sum;
  logic fa_carry;
  logic fa_carry_next;

  serial_full_adder_bit u_fa (
    .clk          (clk),
    .rst          (rst),
    .a_i          (a_q[0]),
    .b_i          (b_q[0]),
    .load_i       (fa_load),
    .cin_init_i   (sub),
    .en_i         (fa_en),
    .sum_o        (fa_sum),
    .carry_o      (fa_carry),
    .carry_next_o (fa_carry_next)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    fa_load = 1'b0;
    fa_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here, the +1 is the initial carry.
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          res_d   = '0;
          cnt_d   = '0;
          fa_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        fa_en = 1'b1;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {fa_sum, res_q[P_WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Carry flop holds the carry into the MSB during the last bit;
          // signed overflow is that carry differing from the carry out.
          state_d = DONE;
          sum_d   = {fa_sum, res_q[P_WIDTH-1:1]};
          cout_d  = fa_carry_next;
          ovf_d   = fa_carry ^ fa_carry_next;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign s_valid   = busy;
  assign s_bit     = busy & fa_sum;
  assign sum_out   = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule
